// File: rtl/compare_pkg.sv
// Shared compare types, one-hot result encodings and the reference compare function.
// Optional per-frame gt counter in compare_stream: COMPARE_STREAM_CNT_EN.
package compare_pkg;

   typedef struct packed {
      logic lt;
      logic eq;
      logic gt;
   } cmp_res_t;

   localparam int CMP_MAXW = 64;

   localparam cmp_res_t CMP_LT = 3'b100;
   localparam cmp_res_t CMP_EQ = 3'b010;
   localparam cmp_res_t CMP_GT = 3'b001;

   // Operands arrive already extended to CMP_MAXW bits.
   function automatic cmp_res_t cmp_fn(
      input logic [CMP_MAXW-1:0] a,
      input logic [CMP_MAXW-1:0] b,
      input logic                signed_mode
   );
      logic lt;
      if (a == b) return CMP_EQ;
      if (signed_mode) lt = $signed(a) < $signed(b);
      else             lt = a < b;
      return lt ? CMP_LT : CMP_GT;
   endfunction

endpackage

// File: rtl/compare_core.sv
// Combinational W-bit magnitude compare, unsigned or two's complement.
// Widths above CMP_MAXW are not supported.
module compare_core
   import compare_pkg::*;
#(
   parameter int W      = 8,
   parameter int SIGNED = 0
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output cmp_res_t     res
);

   localparam int PAD = CMP_MAXW - W;

   logic                ext_a;
   logic                ext_b;
   logic [CMP_MAXW-1:0] ax;
   logic [CMP_MAXW-1:0] bx;

   assign ext_a = (SIGNED != 0) && a[W-1];
   assign ext_b = (SIGNED != 0) && b[W-1];

   if (PAD > 0) begin : g_pad
      assign ax = {{PAD{ext_a}}, a};
      assign bx = {{PAD{ext_b}}, b};
   end else begin : g_nopad
      assign ax = a;
      assign bx = b;
   end

   assign res = cmp_fn(ax, bx, SIGNED != 0);

endmodule

// File: rtl/compare_stream.sv
// Registered valid/ready compare stream with per-frame summary.
// Define COMPARE_STREAM_CNT_EN to add the frm_gt_cnt output.
module compare_stream
   import compare_pkg::*;
#(
   parameter  int W       = 8,
   parameter  int SIGNED  = 0,
   parameter  int MAX_LEN = 16,
   localparam int IDXW    = $clog2(MAX_LEN)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [W-1:0]    in_a,
   input  logic [W-1:0]    in_b,
   input  logic            in_last,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_lt,
   output logic            out_eq,
   output logic            out_gt,
   output logic [IDXW-1:0] out_idx,
   output logic            out_last,
   output logic            frm_all_eq,
   output logic            frm_any_gt,
   output logic [IDXW-1:0] frm_first_gt
`ifdef COMPARE_STREAM_CNT_EN
   ,
   output logic [IDXW:0]   frm_gt_cnt
`endif
);

   cmp_res_t        res;
   logic            acc;
   logic            eff_last;
   logic [IDXW-1:0] idx;
   logic            all_eq;
   logic            any_gt;
   logic [IDXW-1:0] first_gt;
   logic            nxt_all_eq;
   logic            nxt_any_gt;
   logic [IDXW-1:0] nxt_first;

   compare_core #(
      .W      (W),
      .SIGNED (SIGNED)
   ) u_core (
      .a   (in_a),
      .b   (in_b),
      .res (res)
   );

   assign in_ready   = !out_valid || out_ready;
   assign acc        = in_valid && in_ready;
   assign eff_last   = in_last || (idx == IDXW'(MAX_LEN - 1));
   assign nxt_all_eq = all_eq & res.eq;
   assign nxt_any_gt = any_gt | res.gt;
   assign nxt_first  = (res.gt && !any_gt) ? idx : first_gt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid    <= 1'b0;
         out_lt       <= 1'b0;
         out_eq       <= 1'b0;
         out_gt       <= 1'b0;
         out_idx      <= '0;
         out_last     <= 1'b0;
         frm_all_eq   <= 1'b0;
         frm_any_gt   <= 1'b0;
         frm_first_gt <= '0;
         idx          <= '0;
         all_eq       <= 1'b1;
         any_gt       <= 1'b0;
         first_gt     <= '0;
      end else if (acc) begin
         out_valid <= 1'b1;
         out_lt    <= res.lt;
         out_eq    <= res.eq;
         out_gt    <= res.gt;
         out_idx   <= idx;
         out_last  <= eff_last;
         // Closing beat publishes the summary and rearms the accumulators.
         if (eff_last) begin
            frm_all_eq   <= nxt_all_eq;
            frm_any_gt   <= nxt_any_gt;
            frm_first_gt <= nxt_first;
            idx          <= '0;
            all_eq       <= 1'b1;
            any_gt       <= 1'b0;
            first_gt     <= '0;
         end else begin
            idx      <= idx + 1'b1;
            all_eq   <= nxt_all_eq;
            any_gt   <= nxt_any_gt;
            first_gt <= nxt_first;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef COMPARE_STREAM_CNT_EN
   logic [IDXW:0] gt_cnt;
   logic [IDXW:0] nxt_cnt;

   assign nxt_cnt = gt_cnt + (IDXW+1)'(res.gt);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         gt_cnt     <= '0;
         frm_gt_cnt <= '0;
      end else if (acc) begin
         if (eff_last) begin
            frm_gt_cnt <= nxt_cnt;
            gt_cnt     <= '0;
         end else begin
            gt_cnt <= nxt_cnt;
         end
      end
   end
`endif

endmodule
